// File: rtl/qr_read_arbiter.sv
// qr_read_arbiter: round-robin arbiter sharing one frame-buffer BRAM read
// port between the QR pipeline requesters (pattern finder, cross/center
// finder, module sampler). Grants are combinational; a {valid, owner} tag
// pipeline of depth READ_LATENCY routes each returned pixel to its owner.
// Optional feature macro: QR_ARB_LOCK_EN (adds lock_in, lets the last
// granted requester keep the port while it holds lock_in and req_in).
module qr_read_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 20,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]            gnt_out,
`ifdef QR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock_in,
`endif
  output logic [ADDR_WIDTH-1:0]         mem_addr_out,
  input  logic                          mem_pixel_in,
  output logic                          rdata_out,
  output logic [NUM_REQ-1:0]            rdata_valid_out,
  output logic                          busy_out
);

  localparam int unsigned NREQ  = NUM_REQ;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  // Tag pipeline: bit NUM_REQ is valid, low bits are the one-hot owner.
  logic [NUM_REQ:0]        pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] stage_valid;
  logic [NUM_REQ:0]        last_tag;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Round-robin search starting just after the last-granted requester.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((32'(ptr) + i) % NREQ);
      if (!found && req_in[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef QR_ARB_LOCK_EN
    if (lock_in[ptr] && req_in[ptr]) begin
      found   = 1'b1;
      gnt_idx = ptr;
    end
`endif
    if (rst_in) begin
      found = 1'b0;
    end
  end

  // Grant vector and BRAM address of the winner.
  always_comb begin
    gnt_out      = '0;
    mem_addr_out = '0;
    if (found) begin
      gnt_out[gnt_idx] = 1'b1;
      mem_addr_out     = addr_arr[gnt_idx];
    end
  end

  // Last-grant pointer; reset value makes requester 0 win first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr <= PTR_W'(NREQ - 1);
    end else if (found) begin
      ptr <= gnt_idx;
    end
  end

  // Stage 0 captures the current grant every cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe[0] <= '0;
    end else begin
      pipe[0] <= {found, gnt_out};
    end
  end

  for (genvar s = 1; s < READ_LATENCY; s++) begin : g_stage
    // Shift tags toward the return stage; reset drops reads in flight.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        pipe[s] <= '0;
      end else begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  for (genvar s = 0; s < READ_LATENCY; s++) begin : g_valid
    assign stage_valid[s] = pipe[s][NUM_REQ];
  end

  assign last_tag = pipe[READ_LATENCY-1];

  // Return path and busy flag, forced quiet while reset is asserted.
  always_comb begin
    rdata_valid_out = '0;
    if (!rst_in && last_tag[NUM_REQ]) begin
      rdata_valid_out = last_tag[NUM_REQ-1:0];
    end
    rdata_out = (|rdata_valid_out) & mem_pixel_in;
    busy_out  = !rst_in && (found || (|stage_valid));
  end

endmodule

// File: tb/tb_qr_read_arbiter.sv
// Bench for qr_read_arbiter: directed stimulus, a grant/return model with a
// per-cycle compare process, and literal expectations for known scenarios.
module tb_qr_read_arbiter;

  localparam int L    = 2;
  localparam int AW   = 20;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [2:0]    lock;
  logic [AW-1:0] a [3];
  logic [3*AW-1:0] addr_flat;
  logic [2:0]    gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_pixel;
  logic          rdata;
  logic [2:0]    rvalid;
  logic          busy;

  logic [2:0]    req4;
  logic [2:0]    gnt4;
  logic [AW-1:0] mem_addr4;
  logic          rdata4;
  logic [2:0]    rvalid4;
  logic          busy4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign addr_flat = {a[2], a[1], a[0]};

  qr_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .READ_LATENCY(L)) u_dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .req_addr_in(addr_flat),
    .gnt_out(gnt),
`ifdef QR_ARB_LOCK_EN
    .lock_in(lock),
`endif
    .mem_addr_out(mem_addr), .mem_pixel_in(mem_pixel), .rdata_out(rdata),
    .rdata_valid_out(rvalid), .busy_out(busy)
  );

  qr_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .READ_LATENCY(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .req_in(req4), .req_addr_in('0),
    .gnt_out(gnt4),
`ifdef QR_ARB_LOCK_EN
    .lock_in(3'b000),
`endif
    .mem_addr_out(mem_addr4), .mem_pixel_in(1'b0), .rdata_out(rdata4),
    .rdata_valid_out(rvalid4), .busy_out(busy4)
  );

  // Pixel content of the synthetic frame.
  function automatic logic pix(input logic [AW-1:0] ad);
    return ad[0] | ad[1];
  endfunction

  // BRAM stand-in with L cycles of read latency.
  logic [AW-1:0] bq [L];
  always @(posedge clk) begin
    bq[0] <= mem_addr;
    for (int k = 1; k < L; k++) bq[k] <= bq[k-1];
  end
  assign mem_pixel = pix(bq[L-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: grant from arbitration rules, returns from a grant history.
  int            model_ptr = 2;
  int            cyc = 0;
  int            hist_owner [MAXC];
  logic [AW-1:0] hist_addr  [MAXC];

  always @(negedge clk) begin
    int            eg;
    logic [2:0]    e_gnt;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_rv;
    logic          e_rd;
    logic          e_busy;
    eg = -1;
    if (!rst) begin
      for (int i = 1; i <= 3; i++) begin
        int c2;
        c2 = (model_ptr + i) % 3;
        if (eg < 0 && req[c2]) eg = c2;
      end
`ifdef QR_ARB_LOCK_EN
      if (lock[model_ptr] && req[model_ptr]) eg = model_ptr;
`endif
    end
    e_gnt  = (eg >= 0) ? 3'(1 << eg) : 3'b000;
    e_addr = (eg >= 0) ? a[eg] : '0;
    e_rv   = 3'b000;
    e_rd   = 1'b0;
    e_busy = (eg >= 0);
    if (!rst && cyc < MAXC) begin
      if (cyc >= L && hist_owner[cyc-L] >= 0) begin
        e_rv = 3'(1 << hist_owner[cyc-L]);
        e_rd = pix(hist_addr[cyc-L]);
      end
      for (int k = 1; k <= L; k++)
        if (cyc >= k && hist_owner[cyc-k] >= 0) e_busy = 1'b1;
    end
    if (cyc < MAXC) begin
      chk("model_gnt",   32'(gnt),      32'(e_gnt));
      chk("model_addr",  32'(mem_addr), 32'(e_addr));
      chk("model_valid", 32'(rvalid),   32'(e_rv));
      chk("model_rdata", 32'(rdata),    32'(e_rd));
      chk("model_busy",  32'(busy),     32'(e_busy));
      hist_owner[cyc] = eg;
      hist_addr[cyc]  = e_addr;
      if (rst) begin
        model_ptr = 2;
        for (int k = 1; k <= L; k++)
          if (cyc >= k) hist_owner[cyc-k] = -1;
      end else if (eg >= 0) begin
        model_ptr = eg;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; req4 = '0;
    a[0] = 20'd10; a[1] = 20'd20; a[2] = 20'd30;
    @(negedge clk);
    chk("reset_gnt",  32'(gnt),    0);
    chk("reset_busy", 32'(busy),   0);
    chk("reset_rv",   32'(rvalid), 0);
    idle(3);
    rst = 1'b0;
    idle(1);

    // All three requesting: strict rotation 0,1,2,...
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt",  32'(gnt),      32'(1 << (k % 3)));
      chk("rr_addr", 32'(mem_addr), 32'(10 * (k % 3 + 1)));
      if (k >= 2) chk("rr_valid", 32'(rvalid), 32'(1 << ((k - 2) % 3)));
      step();
    end
    req = '0;
    idle(3);

    // Pointer at 2, requesters 0 and 2: wrap-around to 0.
    req = 3'b101;
    @(negedge clk);
    chk("wrap_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    idle(3);

    // Single read from requester 1 at (7,5).
    a[1] = 20'd2407;
    req = 3'b010;
    @(negedge clk);
    chk("single_gnt",   32'(gnt),      32'b010);
    chk("single_addr",  32'(mem_addr), 32'd2407);
    chk("single_busy0", 32'(busy),     1);
    step();
    req = '0;
    @(negedge clk);
    chk("single_busy1", 32'(busy),   1);
    chk("single_rv1",   32'(rvalid), 0);
    step();
    @(negedge clk);
    chk("single_rv2",   32'(rvalid), 32'b010);
    chk("single_rd2",   32'(rdata),  1);
    chk("single_busy2", 32'(busy),   1);
    step();
    @(negedge clk);
    chk("single_busy3", 32'(busy), 0);
    step();

    // Requester 0 drops before being granted; later re-requests back to back.
    req = 3'b101;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'b100);
    step();
    req = 3'b000;
    step();
    req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_gnt", 32'(gnt), 32'b001);
      step();
    end
    req = '0;
    idle(3);

    // Reset right after a grant: no return pulse, requester 0 first after.
    req = 3'b010;
    @(negedge clk);
    chk("rst_pre_gnt", 32'(gnt), 32'b010);
    step();
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("rst_mid_rv",   32'(rvalid), 0);
    chk("rst_mid_busy", 32'(busy),   0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_post_rv", 32'(rvalid), 0);
      step();
    end
    req = 3'b111;
    @(negedge clk);
    chk("rst_first_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    idle(3);

`ifdef QR_ARB_LOCK_EN
    // Lock holds requester 1 until lock_in drops.
    req = 3'b011;
    @(negedge clk);
    chk("lock_first", 32'(gnt), 32'b010);
    step();
    lock = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_hold", 32'(gnt), 32'b010);
      step();
    end
    lock = 3'b000;
    @(negedge clk);
    chk("lock_release", 32'(gnt), 32'b001);
    step();
    req = '0;
    idle(3);
`endif

    // READ_LATENCY=4 instance: 8 grants then 8 returns, 4 cycles later.
    req4 = 3'b001;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("lat4_gnt",   32'(gnt4),    (k < 8) ? 32'b001 : 32'b000);
      chk("lat4_valid", 32'(rvalid4), (k >= 4 && k < 12) ? 32'b001 : 32'b000);
      step();
      if (k == 7) req4 = '0;
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qr_read_arbiter.md
QR_READ_ARBITER -- requirements
Module: qr_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of frame-buffer read requesters (index 0 = pattern finder, 1 = cross/center finder, 2 = module sampler).
REQ-002 Parameter ADDR_WIDTH, default 20, pixel address width (x + y*WIDTH, 480x480 frame).
REQ-003 Parameter READ_LATENCY, default 2, fixed BRAM read latency in cycles; legal range 1..4.
REQ-004 clk_in  input  1  single system clock; all logic on posedge.
REQ-005 rst_in  input  1  reset, synchronous and active-high.
REQ-006 req_in  input  NUM_REQ  per-requester read request; held high with address stable until granted.
REQ-007 req_addr_in  input  NUM_REQ x ADDR_WIDTH  per-requester pixel address.
REQ-008 gnt_out  input-to-output combinational  NUM_REQ  one-hot grant; all zero when no request.
REQ-009 lock_in  input  NUM_REQ  grant-lock request; present only with QR_ARB_LOCK_EN.
REQ-010 mem_addr_out  output  ADDR_WIDTH  BRAM read address.
REQ-011 mem_pixel_in  input  1  BRAM read data (1 = white).
REQ-012 rdata_out  output  1  returned pixel value.
REQ-013 rdata_valid_out  output  NUM_REQ  one-hot, marks owner of rdata_out this cycle.
REQ-014 busy_out  output  1  high while a grant issues or any read is in flight.

Function
REQ-015 Arbitration SHALL be combinational from req_in and a registered last-grant pointer; at most one gnt_out bit high per cycle.
REQ-016 Round-robin: search starts at (pointer+1) mod NUM_REQ, wrapping; first requester with req_in high is granted.
REQ-017 On a grant, pointer SHALL load the granted index at the clock edge; with no grant, pointer holds.
REQ-018 mem_addr_out SHALL equal req_addr_in of the granted requester in the grant cycle, and 0 when no grant.
REQ-019 A tag pipeline of depth READ_LATENCY SHALL carry {valid, one-hot owner}; stage 0 loads the grant each cycle.
REQ-020 rdata_valid_out SHALL equal the last pipeline stage exactly READ_LATENCY cycles after the grant cycle; rdata_out = mem_pixel_in when any rdata_valid_out bit is high, else 0.
REQ-021 Back-to-back grants every cycle SHALL be supported; throughput one read per cycle, returns in grant order.
REQ-022 A requester SHALL be able to re-request in the cycle after its grant; it competes normally under round-robin.
REQ-023 req_in dropped before grant SHALL be ignored without side effects.
REQ-024 busy_out = any gnt_out bit OR any pipeline stage valid.

Reset
REQ-025 While rst_in is high: pointer = NUM_REQ-1 (requester 0 wins first), all pipeline stages invalid, gnt_out = 0, mem_addr_out = 0, rdata_out = 0, rdata_valid_out = 0, busy_out = 0.
REQ-026 Reads in flight at reset SHALL be dropped; no rdata_valid_out pulse for them after rst_in deasserts.

Configuration
REQ-027 Macro QR_ARB_LOCK_EN defined: lock_in exists; if the pointer's requester has lock_in and req_in both high, it is granted again, overriding rotation.
REQ-028 QR_ARB_LOCK_EN undefined: lock_in port absent; pure round-robin per REQ-016.

Verification
REQ-029 Reset, then req_in=3'b111 held, addresses 10/20/30 -> grants cycle 0,1,2,0,...; mem_addr_out 10,20,30,10; each rdata_valid_out 2 cycles after its grant.
REQ-030 Only req 1 at addr 480*5+7=2407, BRAM returns 1 -> gnt_out=3'b010 one cycle, rdata_valid_out=3'b010 and rdata_out=1 two cycles later, busy_out high 3 cycles.
REQ-031 req 2 granted then pointer=2, req 0 and 2 both high -> req 0 granted (wrap-around).
REQ-032 Grant issued, rst_in pulsed on next cycle -> no rdata_valid_out pulse; first post-reset grant goes to req 0.
REQ-033 QR_ARB_LOCK_EN, req_in=3'b011, lock_in=3'b010 after req 1 granted -> req 1 granted every cycle until lock_in drops, then req 0.
REQ-034 READ_LATENCY=4, continuous req 0 for 8 cycles -> 8 consecutive rdata_valid_out pulses starting 4 cycles after first grant.
